// File: rtl/grf_arb_pkg.sv
// Shared types and helpers for the GRF write arbiter slice.
package grf_arb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 32;

    // One queued long-latency result: destination, data and PC for the trace.
    typedef struct packed {
        logic [REG_W-1:0]  wa;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } wb_entry_t;

    // Onehot decode of a register index, used to build the pending mask.
    function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] wa);
        logic [NREGS-1:0] v;
        v     = {NREGS{1'b0}};
        v[wa] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/grf_write_arbiter_if.sv
// Bundle of the W-stage, long-latency source and GRF write port signals.
interface grf_write_arbiter_if #(
    parameter int DEPTH = 4
);
    import grf_arb_pkg::*;

    // W stage
    logic                  w_we;
    logic [REG_W-1:0]      w_wa;
    logic [DATA_W-1:0]     w_wd;
    logic [DATA_W-1:0]     w_pc;
    // long-latency result source
    logic                  u_valid;
    logic                  u_ready;
    logic [REG_W-1:0]      u_wa;
    logic [DATA_W-1:0]     u_wd;
    logic [DATA_W-1:0]     u_pc;
    // GRF write port
    logic                  grf_we;
    logic [REG_W-1:0]      grf_wa;
    logic [DATA_W-1:0]     grf_wd;
    logic [DATA_W-1:0]     grf_pc;
    // decode-side status
    logic [NREGS-1:0]      pending_mask;
    logic                  stall_req;
    logic [$clog2(DEPTH):0] fifo_count;

    // Pipeline / result-source side.
    modport master (
        output w_we, w_wa, w_wd, w_pc,
        output u_valid, u_wa, u_wd, u_pc,
        input  u_ready,
        input  grf_we, grf_wa, grf_wd, grf_pc,
        input  pending_mask, stall_req, fifo_count
    );

    // Arbiter side.
    modport slave (
        input  w_we, w_wa, w_wd, w_pc,
        input  u_valid, u_wa, u_wd, u_pc,
        output u_ready,
        output grf_we, grf_wa, grf_wd, grf_pc,
        output pending_mask, stall_req, fifo_count
    );

endinterface

// File: rtl/grf_wb_fifo.sv
// Ring buffer holding long-latency results until the GRF port is free.
// Pops only from registered occupancy, so an entry pushed this cycle can
// never leave in the same cycle.
module grf_wb_fifo
    import grf_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  wb_entry_t                      push_data,
    input  logic                           pop,
    output wb_entry_t                      head_data,
    output logic [$clog2(DEPTH):0]         count,
    output logic [DEPTH-1:0]               valid,
    output logic [DEPTH-1:0][REG_W-1:0]    wa_vec
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    wb_entry_t          mem_r [DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [CNT_W-1:0]   count_r;
    logic [DEPTH-1:0]   valid_r;
    logic               do_push_s;
    logic               do_pop_s;

    assign do_push_s = push && (count_r != DEPTH_C);
    assign do_pop_s  = pop && (count_r != {CNT_W{1'b0}});

    // Storage, pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            valid_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{wa: {REG_W{1'b0}}, wd: {DATA_W{1'b0}}, pc: {DATA_W{1'b0}}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[tail_r]   <= push_data;
                valid_r[tail_r] <= 1'b1;
                tail_r          <= tail_r + PTR_ONE;
            end
            if (do_pop_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= head_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Expose destination registers of every slot for the pending mask.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wa_vec[i] = mem_r[i].wa;
        end
    end

    assign head_data = mem_r[head_r];
    assign count     = count_r;
    assign valid     = valid_r;

endmodule

// File: rtl/grf_write_arbiter.sv
// Arbitrates the single GRF write port between the W stage (always wins)
// and queued long-latency results, and reports pending registers and a
// starvation stall request to decode.
module grf_write_arbiter
    import grf_arb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    grf_write_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [AGE_W-1:0] LIMIT_C = AGE_W'(STARVE_LIMIT);
    localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);

    wb_entry_t                  head_s;
    wb_entry_t                  push_data_s;
    logic [CNT_W-1:0]           count_s;
    logic [DEPTH-1:0]           valid_s;
    logic [DEPTH-1:0][REG_W-1:0] wa_vec_s;
    logic                       ready_s;
    logic                       push_s;
    logic                       pop_s;
    logic                       w_sel_s;
    logic                       nonempty_s;
    logic                       grf_we_s;
    logic [REG_W-1:0]           grf_wa_s;
    logic [DATA_W-1:0]          grf_wd_s;
    logic [DATA_W-1:0]          grf_pc_s;
    logic [NREGS-1:0]           mask_s;
    logic [AGE_W-1:0]           age_r;
    logic [AGE_W-1:0]           age_next_s;
    logic                       stall_r;

    // Ready depends only on registered occupancy; a full FIFO never accepts
    // even when the head is leaving this cycle.
    assign ready_s     = !reset && (count_s < DEPTH_C);
    assign nonempty_s  = (count_s != {CNT_W{1'b0}});
    assign w_sel_s     = bus.w_we && (bus.w_wa != {REG_W{1'b0}});
    // Results for r0 complete the handshake but are never stored.
    assign push_s      = bus.u_valid && ready_s && (bus.u_wa != {REG_W{1'b0}});
    assign pop_s       = !reset && !w_sel_s && nonempty_s;
    assign push_data_s = '{wa: bus.u_wa, wd: bus.u_wd, pc: bus.u_pc};

    grf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (count_s),
        .valid     (valid_s),
        .wa_vec    (wa_vec_s)
    );

    // Write port mux: W stage first, then FIFO head, otherwise no write.
    always_comb begin
        grf_we_s = 1'b0;
        grf_wa_s = {REG_W{1'b0}};
        grf_wd_s = {DATA_W{1'b0}};
        grf_pc_s = {DATA_W{1'b0}};
        if (reset) begin
            grf_we_s = 1'b0;
        end else if (w_sel_s) begin
            grf_we_s = 1'b1;
            grf_wa_s = bus.w_wa;
            grf_wd_s = bus.w_wd;
            grf_pc_s = bus.w_pc;
        end else if (nonempty_s) begin
            grf_we_s = 1'b1;
            grf_wa_s = head_s.wa;
            grf_wd_s = head_s.wd;
            grf_pc_s = head_s.pc;
        end else begin
            grf_we_s = 1'b0;
        end
    end

    // Pending mask: OR of destination onehots over occupied slots.
    always_comb begin
        mask_s = {NREGS{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_s[i]) begin
                mask_s = mask_s | reg_onehot(wa_vec_s[i]);
            end else begin
                mask_s = mask_s;
            end
        end
    end

    // Age of the head: clears on pop or when empty, otherwise saturates.
    always_comb begin
        age_next_s = age_r;
        if (pop_s || !nonempty_s) begin
            age_next_s = {AGE_W{1'b0}};
        end else if (age_r < LIMIT_C) begin
            age_next_s = age_r + AGE_ONE;
        end else begin
            age_next_s = age_r;
        end
    end

    // Age register and registered starvation request.
    always_ff @(posedge clk) begin
        if (reset) begin
            age_r   <= {AGE_W{1'b0}};
            stall_r <= 1'b0;
        end else begin
            age_r   <= age_next_s;
            stall_r <= (age_next_s >= LIMIT_C);
        end
    end

    assign bus.u_ready      = ready_s;
    assign bus.grf_we       = grf_we_s;
    assign bus.grf_wa       = grf_wa_s;
    assign bus.grf_wd       = grf_wd_s;
    assign bus.grf_pc       = grf_pc_s;
    assign bus.pending_mask = mask_s;
    assign bus.stall_req    = stall_r;
    assign bus.fifo_count   = count_s;

endmodule
